// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants, loader state encoding and bit-reversal helper
package fft_pkg;
  localparam int N = 64;
  localparam int LOG2N = 6;
  localparam int BW = 16;
  typedef enum logic [1:0] {LOAD, FLUSH, HANDOFF} state_e;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/sign_ext_shift.sv
// sign_ext_shift: exact widening of a signed sample with zero-filled pre-shift
module sign_ext_shift #(
  parameter int IW = 12,
  parameter int BW = 16,
  parameter int PRESHIFT = 0
) (
  input  logic [IW-1:0] in_i,
  output logic [BW-1:0] out_o
);
  assign out_o = {{(BW-IW){in_i[IW-1]}}, in_i} << PRESHIFT;
endmodule

// File: rtl/fft_in_loader.sv
// fft_in_loader: widens streamed samples into bit-reversed memory order and hands frames to the FFT
module fft_in_loader
  import fft_pkg::*;
#(
  parameter int IW = 12,
  parameter int PRESHIFT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IW-1:0]    in_re,
  input  logic [IW-1:0]    in_im,
  input  logic             in_last,
  output logic             mem_we,
  output logic [LOG2N-1:0] mem_addr,
  output logic [BW-1:0]    mem_wdata_re,
  output logic [BW-1:0]    mem_wdata_im,
  output logic             len_err,
  output logic             start_req,
  input  logic             start_ack,
  output logic             frame_done
);
  state_e state_q, state_d;
  logic [LOG2N-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [BW-1:0] re_q, re_d, im_q, im_d, wide_re, wide_im;
  logic we_q, we_d, err_q, err_d, req_q, req_d, done_q, done_d, acc, at_end;
  sign_ext_shift #(.IW(IW), .BW(BW), .PRESHIFT(PRESHIFT)) u_re (.in_i(in_re), .out_o(wide_re));
  sign_ext_shift #(.IW(IW), .BW(BW), .PRESHIFT(PRESHIFT)) u_im (.in_i(in_im), .out_o(wide_im));
  assign in_ready = state_q == LOAD;
  assign acc = in_valid && in_ready;
  assign at_end = cnt_q == LOG2N'(N-1);
  // next state, frame counter and the one-cycle-delayed memory write
  always_comb begin
    state_d = state_q == LOAD ? (acc && at_end ? FLUSH : LOAD) :
              state_q == FLUSH ? HANDOFF : (start_ack ? LOAD : HANDOFF);
    cnt_d = acc ? cnt_q + LOG2N'(1) : cnt_q;
    we_d = acc;
    addr_d = acc ? bitrev(cnt_q) : addr_q;
    re_d = acc ? wide_re : re_q;
    im_d = acc ? wide_im : im_q;
    err_d = acc && (in_last != at_end);
    req_d = state_d == HANDOFF;
    done_d = state_q == FLUSH;
  end
  // state and output registers; reset drops any partial frame or pending handoff
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      re_q <= '0;
      im_q <= '0;
      err_q <= 1'b0;
      req_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      re_q <= re_d;
      im_q <= im_d;
      err_q <= err_d;
      req_q <= req_d;
      done_q <= done_d;
    end
  end
  assign mem_we = we_q;
  assign mem_addr = addr_q;
  assign mem_wdata_re = re_q;
  assign mem_wdata_im = im_q;
  assign len_err = err_q;
  assign start_req = req_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_fft_in_loader.sv
// tb_fft_in_loader: randomized scoreboard bench for the FFT input loader
module tb_fft_in_loader;
  localparam int NP = 64;
  localparam int PS = 3;
  typedef struct {
    logic [5:0] a;
    logic [15:0] re;
    logic [15:0] im;
    logic e;
  } exp_t;
  logic clk, rst_n, in_valid, in_ready, in_last, mem_we, len_err, start_req, start_ack, frame_done;
  logic [11:0] in_re, in_im;
  logic [5:0] mem_addr;
  logic [15:0] mem_wdata_re, mem_wdata_im;
  exp_t q[$];
  exp_t e;
  logic [5:0] last_a;
  logic [15:0] last_re, last_im;
  int checks = 0;
  int errors = 0;

  fft_in_loader #(.IW(12), .PRESHIFT(PS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_re(in_re), .in_im(in_im), .in_last(in_last), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata_re(mem_wdata_re), .mem_wdata_im(mem_wdata_im),
    .len_err(len_err), .start_req(start_req), .start_ack(start_ack), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, r);
    end
  endtask

  function automatic logic [5:0] rev(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 6; b++) r = r * 2 + ((k >> b) & 1);
    return 6'(r);
  endfunction

  function automatic logic [15:0] widen(input logic [11:0] x);
    int v;
    v = int'($signed(x));
    return 16'(v * (1 << PS));
  endfunction

  always @(negedge clk) if (rst_n) begin
    if (mem_we) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%0h required no write", mem_addr);
      end else begin
        e = q.pop_front();
        chk("addr", mem_addr, e.a);
        chk("wdata_re", mem_wdata_re, e.re);
        chk("wdata_im", mem_wdata_im, e.im);
        chk("len_err", len_err, e.e);
        last_a = e.a;
        last_re = e.re;
        last_im = e.im;
      end
    end else begin
      chk("idle_len_err", len_err, 0);
      chk("hold_addr", mem_addr, last_a);
      chk("hold_re", mem_wdata_re, last_re);
      chk("hold_im", mem_wdata_im, last_im);
    end
  end

  task automatic do_reset();
    in_valid = 1'b0;
    start_ack = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_re", mem_wdata_re, 0);
    chk("rst_im", mem_wdata_im, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_start_req", start_req, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    q.delete();
    last_a = '0;
    last_re = '0;
    last_im = '0;
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_frame(input int mode, input int pct, input int err_at, input int drop_last,
                           input int ack_delay, input int rst_at, input int rst_ho);
    int k;
    logic v;
    exp_t x;
    k = 0;
    while (k < NP) begin
      chk("in_ready_load", in_ready, 1);
      chk("start_req_load", start_req, 0);
      if (k == rst_at) begin
        in_valid = 1'b0;
        @(negedge clk);
        do_reset();
        return;
      end
      v = $urandom_range(99) < pct;
      in_valid = v;
      start_ack = 1'($urandom_range(1));
      in_re = mode == 0 ? 12'(k) : 12'($urandom);
      in_im = mode == 0 ? 12'(-k) : 12'($urandom);
      if (mode == 1 && k == 5) begin
        in_re = 12'h7FF;
        in_im = 12'h800;
      end
      in_last = (k == err_at) || (k == NP - 1 && drop_last == 0);
      if (v) begin
        x.a = rev(k);
        x.re = widen(in_re);
        x.im = widen(in_im);
        x.e = in_last != (k == NP - 1);
        q.push_back(x);
        k++;
      end
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_re = 12'($urandom);
    in_im = 12'($urandom);
    in_last = 1'b0;
    start_ack = 1'b1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_start_req", start_req, 0);
    chk("flush_frame_done", frame_done, 0);
    @(negedge clk);
    chk("handoff_start_req", start_req, 1);
    chk("handoff_frame_done", frame_done, 1);
    chk("handoff_in_ready", in_ready, 0);
    if (rst_ho != 0) begin
      do_reset();
      return;
    end
    repeat (ack_delay) begin
      start_ack = 1'b0;
      @(negedge clk);
      chk("wait_start_req", start_req, 1);
      chk("wait_frame_done", frame_done, 0);
      chk("wait_in_ready", in_ready, 0);
      chk("wait_mem_we", mem_we, 0);
    end
    start_ack = 1'b1;
    @(negedge clk);
    start_ack = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    in_last = 1'b0;
    start_ack = 1'b0;
    last_a = '0;
    last_re = '0;
    last_im = '0;
    repeat (2) @(negedge clk);
    chk("init_we", mem_we, 0);
    chk("init_addr", mem_addr, 0);
    chk("init_start_req", start_req, 0);
    chk("init_frame_done", frame_done, 0);
    chk("init_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 100, -1, 0, 0, -1, 0);
    run_frame(1, 100, 10, 0, 10, -1, 0);
    run_frame(2, 100, -1, 1, 0, -1, 0);
    run_frame(2, 50, -1, 0, $urandom_range(3), -1, 0);
    run_frame(2, 70, -1, 0, 0, 20, 0);
    run_frame(2, 100, -1, 0, 0, -1, 1);
    run_frame(2, 80, -1, 0, 1, -1, 0);
    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
